// File: rtl/pc_sequencer.sv
// Next-PC controller for the 8-bit fetch stage: PC register, return-address stack and
// a RESET/RUN/HALT sequencer choosing between sequential, branch, jump/call and return.
module pc_sequencer #(
  parameter int         RAS_DEPTH = 4,
  parameter logic [7:0] RESET_VEC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       branch_taken,
  input  logic [7:0] branch_target,
  input  logic       jump,
  input  logic       call,
  input  logic [7:0] jump_target,
  input  logic       ret,
  input  logic       halt_req,
  input  logic       resume,
  output logic [7:0] pc,
  output logic [7:0] pc_next,
  output logic [1:0] pc_src,
  output logic       ras_empty,
  output logic       ras_full,
  output logic       stack_err,
  output logic       halted
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int IW = $clog2(RAS_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);
  localparam logic [CW-1:0] ZERO_C  = CW'(0);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  localparam logic [1:0] SRC_SEQ = 2'b00;
  localparam logic [1:0] SRC_BR  = 2'b01;
  localparam logic [1:0] SRC_JMP = 2'b10;
  localparam logic [1:0] SRC_RET = 2'b11;

  typedef enum logic [1:0] {
    ST_RESET = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [7:0]    pc_r;
  logic [7:0]    pc_next_s;
  logic [7:0]    pc_inc_s;
  logic [7:0]    ras_top_s;
  logic [1:0]    pc_src_s;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic [CW-1:0] count_dec_s;
  logic [IW-1:0] push_idx_s;
  logic [IW-1:0] top_idx_s;
  logic [7:0]    stack_r [RAS_DEPTH];
  logic          push_s;
  logic          pop_s;
  logic          err_set_s;
  logic          err_r;
  logic          empty_r;
  logic          full_r;

  // The stack grows upward: count_r is the next free slot, count_r-1 the top entry.
  assign pc_inc_s    = pc_r + 8'd1;
  assign count_dec_s = count_r - ONE_C;
  assign push_idx_s  = count_r[IW-1:0];
  assign top_idx_s   = count_dec_s[IW-1:0];
  assign ras_top_s   = stack_r[top_idx_s];

  // Next-state, next-PC source selection and stack push/pop decisions.
  always_comb begin
    state_nxt_s = state_r;
    pc_next_s   = pc_r;
    pc_src_s    = SRC_SEQ;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    err_set_s   = 1'b0;
    case (state_r)
      ST_RESET: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (halt_req) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_RUN;
        end
        if (stall) begin
          pc_next_s = pc_r;
        end else if (ret) begin
          // Underflow holds the PC and parks the sequencer in HALT.
          if (count_r == ZERO_C) begin
            err_set_s   = 1'b1;
            state_nxt_s = ST_HALT;
          end else begin
            pc_src_s  = SRC_RET;
            pc_next_s = ras_top_s;
            pop_s     = 1'b1;
          end
        end else if (call) begin
          if (count_r == DEPTH_C) begin
            err_set_s   = 1'b1;
            state_nxt_s = ST_HALT;
          end else begin
            pc_src_s  = SRC_JMP;
            pc_next_s = jump_target;
            push_s    = 1'b1;
          end
        end else if (jump) begin
          pc_src_s  = SRC_JMP;
          pc_next_s = jump_target;
        end else if (branch_taken) begin
          pc_src_s  = SRC_BR;
          pc_next_s = branch_target;
        end else begin
          pc_src_s  = SRC_SEQ;
          pc_next_s = pc_inc_s;
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      default: begin
        state_nxt_s = ST_RESET;
      end
    endcase
    // Reset overrides every request and freezes the fetch-side outputs.
    if (rst) begin
      state_nxt_s = ST_RESET;
      pc_next_s   = pc_r;
      pc_src_s    = SRC_SEQ;
      push_s      = 1'b0;
      pop_s       = 1'b0;
      err_set_s   = 1'b0;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // Stack occupancy after this cycle's push or pop.
  always_comb begin
    count_nxt_s = count_r;
    if (push_s) begin
      count_nxt_s = count_r + ONE_C;
    end else if (pop_s) begin
      count_nxt_s = count_dec_s;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // PC, FSM state, stack occupancy flags and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RESET;
      pc_r    <= RESET_VEC;
      count_r <= ZERO_C;
      err_r   <= 1'b0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_next_s;
      count_r <= count_nxt_s;
      err_r   <= err_r | err_set_s;
      empty_r <= (count_nxt_s == ZERO_C);
      full_r  <= (count_nxt_s == DEPTH_C);
    end
  end

  // Return-address storage; a call saves the wrapped pc+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        stack_r[i] <= 8'h00;
      end
    end else if (push_s) begin
      stack_r[push_idx_s] <= pc_inc_s;
    end
  end

  assign pc        = pc_r;
  assign pc_next   = pc_next_s;
  assign pc_src    = pc_src_s;
  assign ras_empty = empty_r;
  assign ras_full  = full_r;
  assign stack_err = err_r;
  assign halted    = (state_r == ST_HALT);

endmodule
